// File: rtl/crc16_pkg.sv
// CRC-16 shared definitions: polynomial, width, state enum
// and the one-bit LFSR recurrence used by generator and checker.
package crc16_pkg;

  localparam int CRC16_W = 16;
  localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h8005;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    REPORT
  } crc_state_e;

  function automatic logic [CRC16_W-1:0] crc16_step(
    input logic [CRC16_W-1:0] lfsr,
    input logic               b,
    input logic [CRC16_W-1:0] poly
  );
    return {lfsr[CRC16_W-2:0], b}
         ^ (poly & {CRC16_W{lfsr[CRC16_W-1]}});
  endfunction

endpackage

// File: rtl/crc16_lfsr_step.sv
// Combinational one-bit CRC-16 LFSR update (MSB-first).
// Ports: lfsr (current), in_bit (serial bit), lfsr_nxt (updated).
module crc16_lfsr_step
  import crc16_pkg::*;
#(
  parameter logic [CRC16_W-1:0] POLY = CRC16_POLY
) (
  input  logic [CRC16_W-1:0] lfsr,
  input  logic               in_bit,
  output logic [CRC16_W-1:0] lfsr_nxt
);

  assign lfsr_nxt = crc16_step(lfsr, in_bit, POLY);

endmodule

// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 frame checker with length checks and
// saturating good/bad frame counters.
// Ports: clk, rst (sync, active-low); in_valid/in_bit/in_last
// with in_ready; done pulse with held crc_ok/crc_err/len_err,
// rx_crc, frame_bits; good_cnt/bad_cnt statistics.
module crc16_serial_checker
  import crc16_pkg::*;
#(
  parameter logic [CRC16_W-1:0] POLY     = CRC16_POLY,
  parameter int                 MAX_BITS = 4096,
  parameter int                 CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               in_last,
  output logic               in_ready,
  output logic               done,
  output logic               crc_ok,
  output logic               crc_err,
  output logic               len_err,
  output logic [CRC16_W-1:0] rx_crc,
  output logic [12:0]        frame_bits,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   bad_cnt
);

  localparam int FB_W = 13;
  localparam logic [FB_W-1:0] MAX_C = FB_W'(MAX_BITS);
  localparam logic [FB_W-1:0] MIN_C = FB_W'(17);

  crc_state_e state, state_nxt;

  logic [CRC16_W-1:0] lfsr, rx_sh;
  logic [CRC16_W-1:0] lfsr_src, rx_src;
  logic [CRC16_W-1:0] step_out;
  logic [CRC16_W-1:0] lfsr_nxt, rx_nxt;
  logic [FB_W-1:0]    count, cnt_inc, cnt_nxt;
  logic               accept, start, load, fin;
  logic               len_bad, rem_zero;

  assign in_ready = rst & (state != REPORT);
  assign accept   = in_valid & in_ready;
  assign start    = (state == IDLE);
  assign load     = accept & (start | (state == RECV));

  // First beat of a frame shifts into a cleared register,
  // so one step instance covers both load and update.
  assign lfsr_src = start ? '0 : lfsr;
  assign rx_src   = start ? '0 : rx_sh;

  crc16_lfsr_step #(
    .POLY(POLY)
  ) u_step (
    .lfsr    (lfsr_src),
    .in_bit  (in_bit),
    .lfsr_nxt(step_out)
  );

  assign cnt_inc  = start ? FB_W'(1) : count + 13'd1;
  assign lfsr_nxt = load ? step_out : lfsr;
  assign rx_nxt   = load ? {rx_src[CRC16_W-2:0], in_bit}
                         : rx_sh;
  assign cnt_nxt  = load ? cnt_inc : count;

  // Count parks at MAX_BITS+1 in DROP, so one compare
  // flags both runts and overflows.
  assign len_bad  = (cnt_nxt < MIN_C) | (cnt_nxt > MAX_C);
  assign rem_zero = (lfsr_nxt == '0);

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          fin       = in_last;
          state_nxt = in_last ? REPORT : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          if (in_last) begin
            fin       = 1'b1;
            state_nxt = REPORT;
          end else if (cnt_inc > MAX_C) begin
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (accept && in_last) begin
          fin       = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Results are captured on the in_last edge so they are
  // already registered during the REPORT cycle with done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr       <= '0;
      rx_sh      <= '0;
      count      <= '0;
      done       <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      rx_crc     <= '0;
      frame_bits <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      lfsr  <= lfsr_nxt;
      rx_sh <= rx_nxt;
      count <= cnt_nxt;
      done  <= fin;
      if (fin) begin
        len_err    <= len_bad;
        crc_ok     <= ~len_bad & rem_zero;
        crc_err    <= ~len_bad & ~rem_zero;
        rx_crc     <= rx_nxt;
        frame_bits <= cnt_nxt;
        if (~len_bad & rem_zero) begin
          if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
        end else begin
          if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Testbench for crc16_serial_checker: two instances (default
// and MAX_BITS=64/CNT_W=2) checked against a division model.
module tb_crc16_serial_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_last = 1'b0;

  logic        rdy0, done0, ok0, err0, len0;
  logic [15:0] rx0;
  logic [12:0] fb0;
  logic [15:0] good0, bad0;

  logic        rdy1, done1, ok1, err1, len1;
  logic [15:0] rx1;
  logic [12:0] fb1;
  logic [1:0]  good1, bad1;

  int checks = 0;
  int failures = 0;

  int g0 = 0, b0 = 0, g1 = 0, b1 = 0;

  bit fr[$];

  always #5 clk = ~clk;

  crc16_serial_checker u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_bit(in_bit),
    .in_last(in_last), .in_ready(rdy0),
    .done(done0), .crc_ok(ok0), .crc_err(err0),
    .len_err(len0), .rx_crc(rx0), .frame_bits(fb0),
    .good_cnt(good0), .bad_cnt(bad0)
  );

  crc16_serial_checker #(
    .MAX_BITS(64), .CNT_W(2)
  ) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_bit(in_bit),
    .in_last(in_last), .in_ready(rdy1),
    .done(done1), .crc_ok(ok1), .crc_err(err1),
    .len_err(len1), .rx_crc(rx1), .frame_bits(fb1),
    .good_cnt(good1), .bad_cnt(bad1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Remainder of the frame polynomial modulo
  // x^16+x^15+x^2+1 by plain long division.
  function automatic logic [15:0] poly_mod(input int n);
    logic [16:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[15:0], fr[i]};
      if (r[16]) r = r ^ 17'h18005;
    end
    return r[15:0];
  endfunction

  task automatic push_bits(input logic [15:0] v,
                           input int w);
    for (int i = w - 1; i >= 0; i--) fr.push_back(v[i]);
  endtask

  task automatic add_crc();
    logic [15:0] c;
    repeat (16) fr.push_back(1'b0);
    c = poly_mod(fr.size());
    repeat (16) void'(fr.pop_back());
    push_bits(c, 16);
  endtask

  task automatic rand_data(input int n);
    fr.delete();
    for (int i = 0; i < n; i++)
      fr.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic chk_res(
    input string p, input int maxb, input int gc,
    input int bc, input logic d, input logic ok,
    input logic er, input logic ln,
    input logic [15:0] rx, input logic [12:0] fb,
    input logic [15:0] gco, input logic [15:0] bco);
    int n, efb;
    logic [15:0] rem, erx;
    bit elen;
    n    = fr.size();
    elen = (n < 17) || (n > maxb);
    efb  = (n > maxb) ? maxb + 1 : n;
    rem  = poly_mod(n);
    erx  = '0;
    for (int i = (n > 16 ? n - 16 : 0); i < n; i++)
      erx = {erx[14:0], fr[i]};
    chk({p, "_done"}, 32'(d), 1);
    chk({p, "_ok"}, 32'(ok), 32'(!elen && rem == 0));
    chk({p, "_err"}, 32'(er), 32'(!elen && rem != 0));
    chk({p, "_len"}, 32'(ln), 32'(elen));
    chk({p, "_bits"}, 32'(fb), 32'(efb));
    if (n <= maxb) chk({p, "_rx"}, 32'(rx), 32'(erx));
    chk({p, "_good"}, 32'(gco), 32'(gc));
    chk({p, "_bad"}, 32'(bco), 32'(bc));
  endtask

  task automatic model_count(input int maxb, input int sat,
                             inout int g, inout int b);
    int n;
    bit good;
    n = fr.size();
    good = (n >= 17) && (n <= maxb)
        && (poly_mod(n) == 16'h0);
    if (good) g = (g < sat) ? g + 1 : sat;
    else      b = (b < sat) ? b + 1 : sat;
  endtask

  // Drive nbits of fr with random bubbles; bubbles carry
  // random in_last, which must be ignored.
  task automatic send(input int nbits, input int gap,
                      input bit last);
    bit acc;
    int w;
    for (int i = 0; i < nbits; i++) begin
      if (gap > 0) begin
        repeat ($urandom_range(0, gap)) begin
          in_valid = 1'b0;
          in_bit   = 1'($urandom_range(0, 1));
          in_last  = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_bit   = fr[i];
      in_last  = last && (i == nbits - 1);
      w = 0;
      do begin
        acc = rdy0;
        @(negedge clk);
        w++;
      end while (!acc && w < 8);
      chk("accept", 32'(acc), 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int gap);
    send(fr.size(), gap, 1'b1);
    model_count(4096, 65535, g0, b0);
    model_count(64, 3, g1, b1);
    chk("report_rdy0", 32'(rdy0), 0);
    chk("report_rdy1", 32'(rdy1), 0);
    chk_res("u0", 4096, g0, b0, done0, ok0, err0, len0,
            rx0, fb0, good0, bad0);
    chk_res("u1", 64, g1, b1, done1, ok1, err1, len1,
            rx1, fb1, 16'(good1), 16'(bad1));
    @(negedge clk);
    chk("done_pulse", 32'(done0 | done1), 0);
    chk("gap_rdy", 32'(rdy0 & rdy1), 1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(rdy0 | rdy1), 0);
    chk("rst_done", 32'(done0 | done1), 0);
    chk("rst_flags", 32'({ok0, err0, len0, ok1, err1, len1}), 0);
    chk("rst_rx", 32'(rx0 | rx1), 0);
    chk("rst_bits", 32'(fb0 | fb1), 0);
    chk("rst_cnt0", 32'({good0, bad0}), 0);
    chk("rst_cnt1", 32'({good1, bad1}), 0);
    g0 = 0; b0 = 0; g1 = 0; b1 = 0;
    rst = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(rdy0 & rdy1), 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    fr.delete();
    push_bits(16'h01, 8);
    push_bits(16'h8005, 16);
    run_frame(0);
    chk("byte_rx", 32'(rx0), 32'h8005);
    chk("byte_good", 32'(good0), 1);

    fr.delete();
    for (int c = 8'h31; c <= 8'h39; c++)
      push_bits(16'(c), 8);
    push_bits(16'hFEE8, 16);
    run_frame(0);
    chk("check_ok", 32'(ok0), 1);

    fr[10] = ~fr[10];
    run_frame(0);
    chk("flip_err", 32'(err0), 1);
    chk("flip_rx", 32'(rx0), 32'hFEE8);

    fr.delete();
    push_bits(16'h0000, 16);
    run_frame(0);
    chk("runt_len", 32'(len0), 1);

    fr.delete();
    fr.push_back(1'b1);
    run_frame(0);

    rand_data(48);
    add_crc();
    run_frame(1);
    chk("max_ok", 32'(ok1), 1);

    rand_data(65);
    run_frame(1);

    rand_data(100);
    run_frame(0);
    chk("ovf_bits", 32'(fb1), 65);
    chk("ovf_len", 32'(len1), 1);

    for (int k = 0; k < 2; k++) begin
      fr.delete();
      push_bits(16'h01, 8);
      push_bits(16'h8005, 16);
      run_frame(3);
    end

    rand_data(24);
    add_crc();
    send(12, 1, 1'b0);
    do_reset();
    run_frame(1);
    chk("after_rst_good", 32'(good0), 1);

    for (int k = 0; k < 5; k++) begin
      rand_data($urandom_range(8, 40));
      add_crc();
      run_frame(2);
    end
    chk("sat_good", 32'(good1), 3);

    for (int k = 0; k < 6; k++) begin
      rand_data($urandom_range(1, 74));
      if ($urandom_range(0, 1) == 1) add_crc();
      run_frame(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/crc16_serial_checker.md
# crc16_serial_checker

Serial CRC-16 frame checker: the receive-side counterpart of the serial CRC-16 generator. It accepts a bit-serial frame, MSB-first: message bits followed by the 16 check bits the generator produced. It runs the same polynomial division and reports pass/fail, length errors and the received check word per frame. It sits between the bit-level deserializer and frame-level consumers, and keeps saturating good/bad frame counters.

## Interface
- `POLY`, `16'h8005`: generator polynomial without the x^16 term (x^16+x^15+x^2+1); bit 0 must be 1.
- `MAX_BITS`, `4096`: maximum frame length in bits, including the 16 check bits.
- `CNT_W`, `16`: width of the frame statistics counters.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous reset, active-low.
- `in_valid`, in, 1: `in_bit` is valid this cycle.
- `in_bit`, in, 1: serial frame bit, MSB-first.
- `in_last`, in, 1: qualifies the final bit of the frame (the last check bit).
- `in_ready`, out, 1: a beat is accepted when `in_valid & in_ready`.
- `done`, out, 1: one-cycle pulse; the result outputs below are valid.
- `crc_ok`, out, 1: the frame passed. Held until the next `done`.
- `crc_err`, out, 1: remainder was nonzero on a length-valid frame. Held.
- `len_err`, out, 1: runt (<17 bits) or overflow (>`MAX_BITS`). Held.
- `rx_crc`, out, 16: the last 16 bits received, i.e. the transmitted check word. Held.
- `frame_bits`, out, 13: accepted bit count of the frame, saturating at `MAX_BITS`+1. Held.
- `good_cnt`, out, `CNT_W`: frames with `crc_ok`, saturating.
- `bad_cnt`, out, `CNT_W`: frames with `crc_err` or `len_err`, saturating.

## Operation
- **LFSR update per accepted bit:** `lfsr <= {lfsr[14:0], in_bit} ^ (POLY & {16{lfsr[15]}})`. This is the identical recurrence to the generator. The generator's remainder appended MSB-first drives `lfsr` to 0.
- **`rx_crc` shadow:** a 16-bit shift register, `rx_sh <= {rx_sh[14:0], in_bit}`.
- **IDLE:** `in_ready`=1. The first accepted beat loads `lfsr` = `{15'b0, in_bit}`, `rx_sh` likewise, and count = 1.
  - Go to RECV.
  - If that beat also has `in_last`, go straight to REPORT with `len_err`.
- **RECV:** `in_ready`=1.
  - Each accepted beat updates `lfsr`, `rx_sh` and count.
  - Accepted beat with `in_last`: go to REPORT.
  - Accepted beat that takes count past `MAX_BITS` without `in_last`: go to DROP.
- **DROP:** `in_ready`=1. Discard beats until an accepted `in_last`, then go to REPORT with `len_err`=1.
- **REPORT** (one cycle): `in_ready`=0. Register the results.
  - `len_err` = (count<17) | overflow.
  - `crc_ok` = !`len_err` & (`lfsr`==0).
  - `crc_err` = !`len_err` & (`lfsr`!=0).
  - Pulse `done`, update the counters, and return to IDLE.
- **Exclusivity:** exactly one of `crc_ok`, `crc_err`, `len_err` is 1 after each `done`.
- **`in_valid`=0:** cycles with `in_valid` low are bubbles; all state is held.
- **Counters:** saturate at all-ones, never wrap. Only `rst` clears them.
- **Reset values:** with `rst`=0 at a clock edge, every register goes to its reset value.
  - State = IDLE.
  - `lfsr`, `rx_sh` and count = 0.
  - `done`, `crc_ok`, `crc_err`, `len_err` = 0.
  - `rx_crc`, `frame_bits`, `good_cnt`, `bad_cnt` = 0.
  - `in_ready` = 0 during reset, 1 in the first cycle after it.
- **Reset mid-frame:** the partial frame is discarded with no `done` and no counter update.

## Timing
- **Throughput:** one bit per cycle.
- **Result latency:** `done` rises on the first cycle after the `in_last` beat is accepted. Results are visible in that same cycle, as registered outputs.
- **Inter-frame gap:** `in_ready` is low during the REPORT cycle only, giving exactly one dead cycle between frames.
- **`in_last` definition:** `in_last` is only meaningful with `in_valid`; `in_last` without `in_valid` is ignored.
- **Result hold:** result outputs hold their values until the next REPORT cycle overwrites them.

## Structure
- **Shared package `crc16_pkg`:** holds `CRC16_POLY`=16'h8005, `CRC16_W`=16, the `crc16_step(lfsr,bit,poly)` function, and the state enum (IDLE, RECV, DROP, REPORT). The generator is refactored onto the same package.
- **Sub-module `crc16_lfsr_step`:** the combinational one-bit update with parameter `POLY`, instantiated once. The FSM, counters and statistics stay in the top module.

## Test plan
- **Good single-byte frame:** data 0x01 then check 0x8005, 24 bits, MSB-first, `in_last` on bit 24 → `done` one cycle later, `crc_ok`=1, `rx_crc`=0x8005, `frame_bits`=24, `good_cnt`=1.
- **Standard check vector:** ASCII "123456789" (72 bits) plus 0xFEE8 → `crc_ok`=1. Flipping data bit 10 gives `crc_err`=1, `bad_cnt`=1, `rx_crc`=0xFEE8.
- **Runt frame:** 16-bit frame 0x0000 with `in_last` → `len_err`=1, `crc_ok`=0 even though the remainder is 0.
- **Overflow:** `MAX_BITS`=64; send 100 bits, `in_last` on bit 100 → DROP after bit 65, `len_err`=1, `frame_bits`=65.
- **Back-to-back frames with bubbles:** two 0x01/0x8005 frames with random `in_valid` gaps → `in_ready`=0 for exactly one cycle after each `in_last`, `good_cnt`=2.
- **Reset and saturation:**
  - `rst` low after bit 12 of a frame → no `done`; the next full frame checks correctly.
  - With `CNT_W`=2, 5 good frames → `good_cnt`=3.
